// File: rtl/eth_rx_filter_demux.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_filter_demux
// Purpose  : Ethernet header filter. Matching frames have the header stripped
//            and are tagged with a channel index; all other frames are dropped.
// Revision : 1.0  initial release
// ============================================================================
module eth_rx_filter_demux #(
  parameter int DATA_WIDTH = 512,
  parameter int NUM_CH     = 4,
  localparam int c_DB      = DATA_WIDTH / 8,
  localparam int c_DW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [c_DB-1:0]          s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [c_DB-1:0]          m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [c_DW-1:0]          m_axis_tdest,
  output logic                     m_axis_tuser,
  input  logic [47:0]              local_mac,
  input  logic [NUM_CH*48-1:0]     ch_remote_mac,
  input  logic [NUM_CH*16-1:0]     ch_ethertype,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [31:0]              stat_accepted,
  output logic [31:0]              stat_drop_nomatch,
  output logic [31:0]              stat_drop_runt
);

  localparam int c_HDR = 14;
  localparam int c_RES = c_DB - c_HDR;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DROP  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  function automatic logic [7:0] popcnt(input logic [c_DB-1:0] keep);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < c_DB; i++) cnt = cnt + {7'd0, keep[i]};
    return cnt;
  endfunction

  function automatic logic [c_DB-1:0] lo_mask(input int n);
    logic [c_DB-1:0] m;
    for (int i = 0; i < c_DB; i++) m[i] = (i < n);
    return m;
  endfunction

  logic [47:0]           w_dst;
  logic [47:0]           w_src;
  logic [15:0]           w_type;
  logic [NUM_CH-1:0]     w_hit;
  logic [c_DW-1:0]       w_hit_idx;
  logic [7:0]            w_k;
  logic                  w_short;
  logic                  w_out_ready;
  logic                  w_fire;

  logic [8*c_RES-1:0]    r_res;
  logic [c_DB-1:0]       r_flush_keep;
  logic                  r_flush_user;
  logic [c_DW-1:0]       r_dest;

  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [c_DB-1:0]       w_ld_keep;
  logic                  w_ld_last;
  logic                  w_ld_user;
  logic                  w_res_we;
  logic                  w_flush_we;
  logic [c_DB-1:0]       w_flush_keep;
  logic                  w_dest_we;
  logic                  w_inc_acc;
  logic                  w_inc_nomatch;
  logic                  w_inc_runt;

  // Byte 0 is the most significant byte of each header field.
  always_comb begin
    for (int b = 0; b < 6; b++) begin
      w_dst[8*(5-b) +: 8] = s_axis_tdata[8*b +: 8];
      w_src[8*(5-b) +: 8] = s_axis_tdata[8*(b+6) +: 8];
    end
    w_type = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_match
      assign w_hit[g] = ch_enable[g] && (w_dst == local_mac) &&
                        (w_src == ch_remote_mac[48*g +: 48]) &&
                        (w_type == ch_ethertype[16*g +: 16]);
    end
  endgenerate

  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = c_DW'(i);
    end
  end

  assign w_k         = popcnt(s_axis_tkeep);
  assign w_short     = (w_k <= 8'd14);
  assign w_out_ready = !m_axis_tvalid || m_axis_tready;
  assign w_fire      = s_axis_tvalid && s_axis_tready;

  always_comb begin
    w_state_nxt   = r_state;
    s_axis_tready = 1'b0;
    w_load        = 1'b0;
    w_ld_data     = '0;
    w_ld_keep     = '0;
    w_ld_last     = 1'b0;
    w_ld_user     = 1'b0;
    w_res_we      = 1'b0;
    w_flush_we    = 1'b0;
    w_flush_keep  = '0;
    w_dest_we     = 1'b0;
    w_inc_acc     = 1'b0;
    w_inc_nomatch = 1'b0;
    w_inc_runt    = 1'b0;
    case (r_state)
      IDLE: begin
        s_axis_tready = w_out_ready;
        if (w_fire) begin
          if (s_axis_tlast && w_short) begin
            w_inc_runt = 1'b1;
          end else if (w_hit == '0) begin
            w_inc_nomatch = 1'b1;
            if (!s_axis_tlast) w_state_nxt = DROP;
          end else begin
            w_inc_acc = 1'b1;
            w_dest_we = 1'b1;
            if (s_axis_tlast) begin
              w_load    = 1'b1;
              w_ld_data = {{(8*c_HDR){1'b0}}, s_axis_tdata[DATA_WIDTH-1:8*c_HDR]};
              w_ld_keep = lo_mask(int'(w_k) - c_HDR);
              w_ld_last = 1'b1;
              w_ld_user = s_axis_tuser;
            end else begin
              w_res_we    = 1'b1;
              w_state_nxt = PASS;
            end
          end
        end
      end
      PASS: begin
        s_axis_tready = w_out_ready;
        if (w_fire) begin
          w_load    = 1'b1;
          w_ld_data = {s_axis_tdata[8*c_HDR-1:0], r_res};
          w_ld_keep = '1;
          w_res_we  = 1'b1;
          if (s_axis_tlast && w_short) begin
            w_ld_keep   = lo_mask(c_RES + int'(w_k));
            w_ld_last   = 1'b1;
            w_ld_user   = s_axis_tuser;
            w_state_nxt = IDLE;
          end else if (s_axis_tlast) begin
            // Tail overflows the beat; its remainder leaves on a FLUSH beat.
            w_flush_we   = 1'b1;
            w_flush_keep = lo_mask(int'(w_k) - c_HDR);
            w_state_nxt  = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (w_out_ready) begin
          w_load      = 1'b1;
          w_ld_data   = {{(8*c_HDR){1'b0}}, r_res};
          w_ld_keep   = r_flush_keep;
          w_ld_last   = 1'b1;
          w_ld_user   = r_flush_user;
          w_state_nxt = IDLE;
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_res        <= '0;
      r_flush_keep <= '0;
      r_flush_user <= 1'b0;
      r_dest       <= '0;
    end else begin
      if (w_res_we)  r_res <= s_axis_tdata[DATA_WIDTH-1:8*c_HDR];
      if (w_flush_we) begin
        r_flush_keep <= w_flush_keep;
        r_flush_user <= s_axis_tuser;
      end
      if (w_dest_we) r_dest <= w_hit_idx;
    end
  end

  assign m_axis_tdest = r_dest;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (w_load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= w_ld_data;
      m_axis_tkeep  <= w_ld_keep;
      m_axis_tlast  <= w_ld_last;
      m_axis_tuser  <= w_ld_user;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_accepted     <= '0;
      stat_drop_nomatch <= '0;
      stat_drop_runt    <= '0;
    end else begin
      if (w_inc_acc && (stat_accepted != '1))         stat_accepted     <= stat_accepted + 32'd1;
      if (w_inc_nomatch && (stat_drop_nomatch != '1)) stat_drop_nomatch <= stat_drop_nomatch + 32'd1;
      if (w_inc_runt && (stat_drop_runt != '1))       stat_drop_runt    <= stat_drop_runt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_filter_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_filter_demux
// Purpose  : Self-checking bench with a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_rx_filter_demux;

  localparam int DB = 64;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [511:0]  s_axis_tdata = '0;
  logic [63:0]   s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic [511:0]  m_axis_tdata;
  logic [63:0]   m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [1:0]    m_axis_tdest;
  logic          m_axis_tuser;
  logic [47:0]   local_mac = 48'h02_11_22_33_44_55;
  logic [191:0]  ch_remote_mac;
  logic [63:0]   ch_ethertype;
  logic [3:0]    ch_enable = 4'hF;
  logic [31:0]   stat_accepted, stat_drop_nomatch, stat_drop_runt;

  initial forever #5 ap_clk = ~ap_clk;

  eth_rx_filter_demux #(.DATA_WIDTH(512), .NUM_CH(4)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .m_axis_tuser(m_axis_tuser), .local_mac(local_mac),
    .ch_remote_mac(ch_remote_mac), .ch_ethertype(ch_ethertype),
    .ch_enable(ch_enable), .stat_accepted(stat_accepted),
    .stat_drop_nomatch(stat_drop_nomatch), .stat_drop_runt(stat_drop_runt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] kmask(input int n);
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = (i < n);
    return m;
  endfunction

  // Reference model: an accepted frame's output is its payload cut into DB-byte chunks.
  typedef struct {
    logic [511:0] data;
    int           n;
    logic         last;
    logic         user;
    logic [1:0]   dest;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] frm[$];
  int         exp_acc = 0, exp_nm = 0, exp_runt = 0;

  function automatic int model_hit();
    logic [47:0] d, s;
    logic [15:0] t;
    d = '0; s = '0;
    for (int b = 0; b < 6; b++) begin
      d = {d[39:0], frm[b]};
      s = {s[39:0], frm[6+b]};
    end
    t = {frm[12], frm[13]};
    for (int i = 0; i < 4; i++)
      if (ch_enable[i] && d == local_mac && s == ch_remote_mac[48*i +: 48] &&
          t == ch_ethertype[16*i +: 16]) return i;
    return -1;
  endfunction

  task automatic model_frame(input logic usr);
    int L, h, P;
    L = frm.size();
    if (L <= 14) begin exp_runt++; return; end
    h = model_hit();
    if (h < 0) begin exp_nm++; return; end
    exp_acc++;
    P = L - 14;
    for (int off = 0; off < P; off += DB) begin
      beat_t bt;
      bt.data = '0;
      bt.n    = (P - off < DB) ? P - off : DB;
      for (int j = 0; j < bt.n; j++) bt.data[8*j +: 8] = frm[14+off+j];
      bt.last = (off + DB >= P);
      bt.user = bt.last ? usr : 1'b0;
      bt.dest = 2'(h);
      exp_q.push_back(bt);
    end
  endtask

  task automatic build_frame(input int len, input int ch, input int kind);
    logic [47:0] d, s;
    logic [15:0] t;
    d = local_mac;
    s = ch_remote_mac[48*ch +: 48];
    t = ch_ethertype[16*ch +: 16];
    if (kind == 1) d = d ^ (48'd1 << $urandom_range(47, 0));
    if (kind == 2) s = s ^ (48'd1 << $urandom_range(47, 0));
    if (kind == 3) t = t ^ (16'd1 << $urandom_range(15, 0));
    frm.delete();
    for (int b = 0; b < 6; b++) frm.push_back(d[8*(5-b) +: 8]);
    for (int b = 0; b < 6; b++) frm.push_back(s[8*(5-b) +: 8]);
    frm.push_back(t[15:8]);
    frm.push_back(t[7:0]);
    while (frm.size() < len) frm.push_back(8'($urandom));
    while (frm.size() > len) void'(frm.pop_back());
  endtask

  // Called at a negedge; returns at a negedge after the last handshake.
  task automatic send_frame(input logic usr, input int max_beats, input bit gaps);
    int L, nb, nsend, g;
    L     = frm.size();
    nb    = (L + DB - 1) / DB;
    nsend = (max_beats < nb) ? max_beats : nb;
    for (int b = 0; b < nsend; b++) begin
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      for (int j = 0; j < DB; j++)
        if (b*DB + j < L) begin
          s_axis_tdata[8*j +: 8] = frm[b*DB+j];
          s_axis_tkeep[j] = 1'b1;
        end
      s_axis_tlast  = (b == nb - 1);
      s_axis_tuser  = s_axis_tlast ? usr : 1'($urandom);
      s_axis_tvalid = 1'b1;
      #1;
      g = 0;
      while (!s_axis_tready) begin
        @(negedge ap_clk); #1;
        g++;
        if (g > 2000) begin
          $display("FAIL input_stall actual=tready_low required=handshake_within_2000");
          failures++;
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $fatal(1, "input stalled");
        end
      end
      @(negedge ap_clk);
      if (gaps && $urandom_range(3, 0) == 0) begin
        s_axis_tvalid = 1'b0;
        @(negedge ap_clk);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  bit rdy_rand = 1'b0;
  initial forever begin
    @(negedge ap_clk);
    m_axis_tready = rdy_rand ? 1'($urandom) : 1'b1;
  end

  int          out_beats = 0, low_rdy = 0, last_n = 0;
  logic [63:0] last_keep = '0;
  logic [1:0]  last_dest = '0;
  logic        last_last = 1'b0, last_user = 1'b0;

  initial begin
    beat_t e;
    int    bad;
    forever begin
      @(negedge ap_clk); #2;
      if (ap_rst_n && !s_axis_tready) low_rdy++;
      if (ap_rst_n && m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        last_keep = m_axis_tkeep;
        last_dest = m_axis_tdest;
        last_last = m_axis_tlast;
        last_user = m_axis_tuser;
        last_n = 0;
        for (int j = 0; j < 64; j++) last_n += int'(m_axis_tkeep[j]);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=keep_0x%0h required=no_beat", m_axis_tkeep);
        end else begin
          e = exp_q.pop_front();
          chk("tkeep", m_axis_tkeep, kmask(e.n));
          chk("tlast", 64'(m_axis_tlast), 64'(e.last));
          chk("tuser", 64'(m_axis_tuser), 64'(e.user));
          chk("tdest", 64'(m_axis_tdest), 64'(e.dest));
          bad = -1;
          for (int j = 0; j < e.n; j++)
            if (bad < 0 && m_axis_tdata[8*j +: 8] !== e.data[8*j +: 8]) bad = j;
          checks++;
          if (bad >= 0) begin
            failures++;
            $display("FAIL tdata byte %0d actual=0x%0h required=0x%0h",
                     bad, m_axis_tdata[8*bad +: 8], e.data[8*bad +: 8]);
          end
        end
      end
    end
  end

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && g < 1000) begin
      @(negedge ap_clk);
      g++;
    end
    checks++;
    if (g >= 1000) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    repeat (3) @(negedge ap_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, l0;
    for (int i = 0; i < 4; i++) begin
      ch_remote_mac[48*i +: 48] = 48'hA0_00_00_00_00_00 | 48'(i * 48'h0101_0101);
      ch_ethertype[16*i +: 16]  = 16'h88B0 + 16'(i);
    end
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    #2;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tkeep", m_axis_tkeep, 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
    chk("rst_tdest", 64'(m_axis_tdest), 64'd0);
    chk("rst_stats", 64'(stat_accepted | stat_drop_nomatch | stat_drop_runt), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    build_frame(60, 2, 0); model_frame(1'b0); send_frame(1'b0, 99, 1'b0); drain();
    chk("t60_keep", last_keep, 64'h3FFF_FFFF_FFFF);
    chk("t60_dest", 64'(last_dest), 64'd2);
    chk("t60_last", 64'(last_last), 64'd1);
    chk("t60_beats", 64'(out_beats), 64'd1);
    chk("t60_acc", 64'(stat_accepted), 64'd1);

    b0 = out_beats; l0 = low_rdy;
    build_frame(100, 0, 0); model_frame(1'b0); send_frame(1'b0, 99, 1'b0); drain();
    chk("t100_beats", 64'(out_beats - b0), 64'd2);
    chk("t100_tail", 64'(last_n), 64'd22);
    chk("t100_flush", 64'(low_rdy - l0), 64'd1);

    b0 = out_beats; l0 = low_rdy;
    build_frame(78, 1, 0); model_frame(1'b1); send_frame(1'b1, 99, 1'b0); drain();
    chk("t78_beats", 64'(out_beats - b0), 64'd1);
    chk("t78_n", 64'(last_n), 64'd64);
    chk("t78_user", 64'(last_user), 64'd1);
    chk("t78_noflush", 64'(low_rdy - l0), 64'd0);

    b0 = out_beats; l0 = low_rdy;
    build_frame(150, 3, 2); model_frame(1'b0); send_frame(1'b0, 99, 1'b0); drain();
    chk("drop_beats", 64'(out_beats - b0), 64'd0);
    chk("drop_ready", 64'(low_rdy - l0), 64'd0);
    chk("drop_nomatch", 64'(stat_drop_nomatch), 64'd1);
    build_frame(12, 0, 0); model_frame(1'b0); send_frame(1'b0, 99, 1'b0); drain();
    chk("runt_cnt", 64'(stat_drop_runt), 64'd1);
    chk("acc_after_drops", 64'(stat_accepted), 64'd3);

    ch_remote_mac[48 +: 48] = ch_remote_mac[96 +: 48];
    ch_ethertype[16 +: 16]  = ch_ethertype[32 +: 16];
    ch_enable = 4'b0110;
    build_frame(70, 2, 0); model_frame(1'b0); send_frame(1'b0, 99, 1'b0); drain();
    chk("prio_dest", 64'(last_dest), 64'd1);
    ch_remote_mac[48 +: 48] = 48'hA0_01_01_01_01_01;
    ch_ethertype[16 +: 16]  = 16'h88B1;
    ch_enable = 4'hF;

    rdy_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int r, kind;
      r = $urandom_range(9, 0);
      kind = (r < 6) ? 0 : 1 + (r % 3);
      build_frame($urandom_range(1, 200), $urandom_range(3, 0), kind);
      model_frame(1'(i % 2));
      send_frame(1'(i % 2), 99, 1'b1);
    end
    drain();
    rdy_rand = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk("rand_acc", 64'(stat_accepted), 64'(exp_acc));
    chk("rand_nomatch", 64'(stat_drop_nomatch), 64'(exp_nm));
    chk("rand_runt", 64'(stat_drop_runt), 64'(exp_runt));

    build_frame(200, 0, 0); model_frame(1'b0); send_frame(1'b0, 2, 1'b0);
    #1;
    chk("pre_rst_valid", 64'(m_axis_tvalid), 64'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
    exp_q.delete();
    exp_acc = 0; exp_nm = 0; exp_runt = 0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_acc", 64'(stat_accepted), 64'd0);
    b0 = out_beats;
    build_frame(100, 3, 0); model_frame(1'b1); send_frame(1'b1, 99, 1'b0); drain();
    chk("post_rst_beats", 64'(out_beats - b0), 64'd2);
    chk("post_rst_dest", 64'(last_dest), 64'd3);
    chk("post_rst_user", 64'(last_user), 64'd1);
    chk("post_rst_acc1", 64'(stat_accepted), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_rx_filter_demux.md
# eth_rx_filter_demux

Multi-channel receive front end for the Ethernet path, placed between the MAC's 512-bit RX stream and the user payload streams. It parses the 14-byte Ethernet header on the first beat of every frame and matches it against a table of NUM_CH channel entries. Frames that match have the header stripped, the payload realigned to byte 0 and the winning channel index driven on tdest. Frames that do not match, or that carry no payload, are discarded whole and counted.

## Interface
- DATA_WIDTH, 512, stream width in bits; legal values 128, 256, 512; DB = DATA_WIDTH/8 bytes
- NUM_CH, 4, number of filter channels (1..16); DW = max(1, clog2(NUM_CH))
- ap_clk  in  1  single clock for all logic
- ap_rst_n  in  1  reset; asynchronous assert, active-low
- s_axis_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  DATA_WIDTH/DB/1/1/1  Ethernet frame input; tkeep contiguous from bit 0
- s_axis_tuser  in  1  frame error flag, sampled on the tlast beat
- m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  DATA_WIDTH/DB/1/1/1  stripped payload
- m_axis_tdest  out  DW  matched channel index, constant for the whole frame
- m_axis_tuser  out  1  error flag, valid on the output tlast beat, 0 elsewhere
- local_mac  in  48  destination MAC to accept
- ch_remote_mac  in  NUM_CH*48  per-channel expected source MAC; entry i in bits [48i+47:48i]
- ch_ethertype  in  NUM_CH*16  per-channel ethertype
- ch_enable  in  NUM_CH  per-channel enable
- stat_accepted, stat_drop_nomatch, stat_drop_runt  out  32 each  saturating frame counters

## Operation
- Byte order: stream byte n is tdata[8n+7:8n].
  - dest MAC = {byte0..byte5}, with byte0 as the MSB.
  - src MAC = {byte6..byte11}.
  - type = {byte12, byte13}.
- Match on the first beat: channel i hits when ch_enable[i], dest == local_mac, src == ch_remote_mac[i] and type == ch_ethertype[i].
  - The lowest hit index wins.
  - The decision and tdest are latched on the first beat. Configuration changes mid-frame do not affect the frame in progress.
- Runt frame: first beat has tlast with popcount(tkeep) K <= 14. It is dropped, stat_drop_runt increments and the runt check takes priority over matching.
- FSM states: IDLE, PASS, DROP, FLUSH.
- IDLE, on first-beat accept:
  - Runt or no hit → back to IDLE (runt) or to DROP (no hit, not tlast). stat_drop_nomatch increments for a no-hit non-runt frame.
  - Hit and tlast → emit one beat holding bytes 14..K-1, K-14 bytes, tlast=1. stat_accepted increments. Stay in IDLE.
  - Hit and not tlast → store bytes 14..DB-1 in the residual register (R = DB-14 bytes) and go to PASS. stat_accepted increments.
- PASS, on accepting a beat with K bytes:
  - Output = residual in low R bytes, input bytes 0..13 in the top 14 bytes.
  - Residual ← input bytes 14..DB-1.
  - If tlast and K <= 14: output is the last beat with R+K bytes; go to IDLE.
  - If tlast and K > 14: output a full non-last beat, then go to FLUSH.
- FLUSH: emit the residual as K-14 bytes with tlast, then go to IDLE. s_axis_tready=0 while in this state.
- DROP: s_axis_tready=1; beats are consumed with no output; tlast → IDLE.
- m_axis_tuser = the s_axis_tuser value captured on the input tlast beat, driven on the output tlast beat.
- Unused output tkeep bits are 0. tdata in unused bytes is don't-care.
- Counters saturate at 0xFFFFFFFF.

## Timing
- Reset values: m_axis_tvalid=0, tlast=0, tuser=0, tdest=0, tkeep=0; all counters 0; state IDLE.
- Reset is asynchronous and may assert mid-frame. After deassertion, the next input beat is parsed as a new frame's first beat.
- Output stage is a single register.
  - IDLE and PASS: s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - DROP: s_axis_tready = 1 regardless of the output stage.
- Latency:
  - Output beat for input beat n (n ≥ 1) is valid the cycle after that beat is accepted.
  - Single-beat frame: output valid 1 cycle after accept.
  - FLUSH beat: presented the cycle after the preceding output beat is accepted.
- Throughput: 1 beat/cycle with m_axis_tready held high. FLUSH costs one input bubble per frame.
- Back-to-back frames: a first beat may be accepted in the cycle immediately after the previous tlast, or after FLUSH completes.
- Counters update 1 cycle after the deciding first-beat handshake.

## Test plan
- DATA_WIDTH=512, 60-byte frame, single beat, matching ch2 → one output beat with tkeep=0x3FFF_FFFF_FFFF (46 bytes), tdest=2, tlast=1; stat_accepted=1.
- 100-byte frame matching ch0, input beats of 64 and 36 bytes → two output beats: 64 bytes (payload bytes 0..63) then 22 bytes with tlast; one FLUSH cycle with s_axis_tready=0.
- 78-byte frame matching ch1, input beats of 64 and 14 bytes → one 64-byte beat with tlast and no FLUSH cycle.
- Source MAC mismatch with a 3-beat frame → no output, s_axis_tready=1 for all 3 beats, stat_drop_nomatch=1. A 12-byte single beat → stat_drop_runt=1.
- Two channels both hit, ch_enable=4'b0110 → tdest=1. With m_axis_tready toggling 50% over 20 random frames → payload byte-exact against the model, and tuser=1 when set on the input tlast beat.
- ap_rst_n asserted mid-frame in PASS → m_axis_tvalid=0 immediately. The following clean frame is parsed correctly.
